risc_v_run_controller: RTL and testbench

RISC_V_RUN_CONTROLLER -- requirements
Module: risc_v_run_controller

---
 rtl/risc_v_run_controller.sv | 97 +++++++++
 tb/tb_risc_v_run_controller.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/risc_v_run_controller.sv
// risc_v_run_controller: sequences core reset, watches the PC for halt or self-loop, then grades results.
module risc_v_run_controller #(
   parameter int XLEN        = 64,
   parameter int NUM_ELEM    = 8,
   parameter int RST_CYCLES  = 3,
   parameter int HALT_REPEAT = 2,
   parameter int TIMEOUT     = 1024,
   parameter int CNT_W       = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [XLEN-1:0]          pc_out,
   input  logic [XLEN-1:0]          halt_pc,
   input  logic [NUM_ELEM*XLEN-1:0] elements,
   input  logic [NUM_ELEM*XLEN-1:0] expected,
   output logic                     core_reset,
   output logic                     running,
   output logic                     done,
   output logic                     pass,
   output logic [NUM_ELEM-1:0]      fail_mask,
   output logic                     timeout,
   output logic [CNT_W-1:0]         cycle_count
);
   localparam int RW = RST_CYCLES > 1 ? $clog2(RST_CYCLES) : 1;
   localparam int HW = $clog2(HALT_REPEAT + 1);
   typedef enum logic [2:0] {IDLE, RSTSEQ, RUN, CHECK, DONE} state_t;
   state_t              state, state_nx;
   logic [RW-1:0]       rst_cnt;
   logic [HW-1:0]       halt_cnt, loop_cnt, halt_nx, loop_nx;
   logic [XLEN-1:0]     prev_pc;
   logic                prev_vld, halt, tmo;
   logic [CNT_W-1:0]    cnt_nx;
   logic [NUM_ELEM-1:0] mismatch;
   for (genvar i = 0; i < NUM_ELEM; i++) begin : g_cmp
      assign mismatch[i] = elements[i*XLEN +: XLEN] != expected[i*XLEN +: XLEN];
   end
   assign core_reset = state == IDLE || state == RSTSEQ;
   assign running    = state == RUN;
   assign done       = state == DONE;
   always_comb begin
      halt_nx  = pc_out == halt_pc ? halt_cnt + 1'b1 : '0;
      loop_nx  = prev_vld && pc_out == prev_pc ? loop_cnt + 1'b1 : '0;
      halt     = halt_nx == HW'(HALT_REPEAT) || loop_nx == HW'(HALT_REPEAT);
      cnt_nx   = &cycle_count ? cycle_count : cycle_count + 1'b1;
      tmo      = cnt_nx == CNT_W'(TIMEOUT);
      state_nx = state;
      case (state)
         IDLE:    state_nx = start ? RSTSEQ : IDLE;
         RSTSEQ:  state_nx = rst_cnt == RW'(RST_CYCLES - 1) ? RUN : RSTSEQ;
         RUN:     state_nx = halt ? CHECK : tmo ? DONE : RUN;
         CHECK:   state_nx = DONE;
         DONE:    state_nx = start ? RSTSEQ : DONE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         rst_cnt     <= '0;
         halt_cnt    <= '0;
         loop_cnt    <= '0;
         prev_pc     <= '0;
         prev_vld    <= 1'b0;
         cycle_count <= '0;
         pass        <= 1'b0;
         fail_mask   <= '0;
         timeout     <= 1'b0;
      end else begin
         state <= state_nx;
         if (state_nx == RSTSEQ && state != RSTSEQ) begin
            rst_cnt     <= '0;
            halt_cnt    <= '0;
            loop_cnt    <= '0;
            prev_vld    <= 1'b0;
            cycle_count <= '0;
            pass        <= 1'b0;
            fail_mask   <= '0;
            timeout     <= 1'b0;
         end
         if (state == RSTSEQ) rst_cnt <= rst_cnt + 1'b1;
         if (state == RUN) begin
            cycle_count <= cnt_nx;
            halt_cnt    <= halt_nx;
            loop_cnt    <= loop_nx;
            prev_pc     <= pc_out;
            prev_vld    <= 1'b1;
            // halt wins over a simultaneous timeout
            if (!halt && tmo) timeout <= 1'b1;
         end
         if (state == CHECK) begin
            fail_mask <= mismatch;
            pass      <= ~|mismatch;
         end
      end
   end
endmodule

// File: tb/tb_risc_v_run_controller.sv
// tb_risc_v_run_controller: random and directed runs checked every cycle against a history-based model.
module tb_risc_v_run_controller;
   localparam int XLEN = 16, NE = 8, RST = 3, HR = 2, TO = 16, CW = 8;
   logic              clk = 0, reset, start;
   logic [XLEN-1:0]   pc_out, halt_pc;
   logic [NE*XLEN-1:0] elements, expected;
   logic              core_reset, running, done, pass, timeout;
   logic [NE-1:0]     fail_mask;
   logic [CW-1:0]     cycle_count;
   int                n_cmp = 0, n_bad = 0;
   risc_v_run_controller #(.XLEN(XLEN), .NUM_ELEM(NE), .RST_CYCLES(RST), .HALT_REPEAT(HR),
      .TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .start(start), .pc_out(pc_out), .halt_pc(halt_pc),
      .elements(elements), .expected(expected), .core_reset(core_reset), .running(running),
      .done(done), .pass(pass), .fail_mask(fail_mask), .timeout(timeout), .cycle_count(cycle_count));
   always #5 clk = ~clk;
   // model: run phase flags plus the PC history of the current run
   bit              m_ok = 0, m_idle, m_done, m_run, m_chk, m_pass, m_tmo;
   int              m_seq, m_cnt;
   logic [NE-1:0]   m_mask;
   logic [XLEN-1:0] hist[$];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic bit halted();
      int n = hist.size();
      bit hit = n >= HR, lp = n >= HR + 1;
      for (int j = 0; j < HR && hit; j++) if (hist[n-1-j] != halt_pc) hit = 0;
      for (int j = 0; j <= HR && lp; j++) if (hist[n-1-j] != hist[n-1]) lp = 0;
      return hit || lp;
   endfunction
   always @(posedge clk) begin
      if (!reset) begin
         m_ok = 1; m_idle = 1; m_done = 0; m_run = 0; m_chk = 0; m_seq = 0;
         m_cnt = 0; m_pass = 0; m_mask = 0; m_tmo = 0; hist.delete();
      end else if (m_ok) begin
         if ((m_idle || m_done) && start) begin
            m_idle = 0; m_done = 0; m_seq = RST; m_cnt = 0; m_pass = 0; m_mask = 0; m_tmo = 0;
            hist.delete();
         end else if (m_seq > 0) begin
            m_seq--;
            m_run = m_seq == 0;
         end else if (m_run) begin
            hist.push_back(pc_out);
            if (m_cnt < 255) m_cnt++;
            if (halted()) begin m_run = 0; m_chk = 1; end
            else if (m_cnt == TO) begin m_run = 0; m_done = 1; m_tmo = 1; end
         end else if (m_chk) begin
            for (int i = 0; i < NE; i++) m_mask[i] = elements[i*XLEN +: XLEN] != expected[i*XLEN +: XLEN];
            m_pass = m_mask == 0;
            m_chk = 0; m_done = 1;
         end
      end
   end
   always @(negedge clk) if (m_ok) begin
      chk("core_reset", 32'(core_reset), 32'(m_idle || m_seq > 0));
      chk("running", 32'(running), 32'(m_run));
      chk("done", 32'(done), 32'(m_done));
      chk("pass", 32'(pass), 32'(m_pass));
      chk("fail_mask", 32'(fail_mask), 32'(m_mask));
      chk("timeout", 32'(timeout), 32'(m_tmo));
      chk("cycle_count", 32'(cycle_count), 32'(m_cnt));
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic set_elems(input bit flips);
      for (int i = 0; i < NE; i++) begin
         logic [XLEN-1:0] e = XLEN'($urandom);
         expected[i*XLEN +: XLEN] = e;
         elements[i*XLEN +: XLEN] = flips && $urandom_range(3) == 0 ? e ^ XLEN'(1 << $urandom_range(15)) : e;
      end
   endtask
   // mode 0 ramp to halt_pc, 1 self-loop, 2 never repeats, 3 random, 4 halt on the timeout cycle
   task automatic run(input int mode);
      int k = 0;
      start = 1;
      tick();
      start = 0;
      chk("entry_count", 32'(cycle_count), 0);
      chk("entry_timeout", 32'(timeout), 0);
      for (int i = 0; i < RST; i++) begin
         chk("rstseq_core_reset", 32'(core_reset), 1);
         tick();
      end
      chk("run_entry", 32'(running), 1);
      while (!m_done && k < 40) begin
         case (mode)
            0: pc_out = k < 4 ? XLEN'(16'h30 + 4 * k) : 16'h40;
            1: pc_out = 16'h1C;
            2: pc_out = XLEN'(16'h100 + 4 * k);
            3: begin
               int r = $urandom_range(3);
               pc_out = r == 0 ? halt_pc : r == 1 ? pc_out : XLEN'(16'h200 + 4 * $urandom_range(63));
               start = $urandom_range(1);
            end
            default: pc_out = k < 14 ? XLEN'(16'h100 + 4 * k) : 16'h40;
         endcase
         tick();
         k++;
      end
      start = 0;
      if (!m_done) begin
         n_cmp++; n_bad++;
         $display("FAIL run_bound: no completion within 40 cycles, mode %0d", mode);
      end
   endtask
   initial begin
      reset = 0; start = 0; pc_out = 0; halt_pc = 16'h40; elements = '0; expected = '0;
      tick();
      start = 1;
      tick();
      chk("rst_core_reset", 32'(core_reset), 1);
      chk("rst_done", 32'(done), 0);
      chk("rst_count", 32'(cycle_count), 0);
      chk("rst_running", 32'(running), 0);
      start = 0; reset = 1;
      tick();
      chk("idle_core_reset", 32'(core_reset), 1);
      set_elems(0);
      run(0);
      chk("halt_pass", 32'(pass), 1);
      chk("halt_mask", 32'(fail_mask), 0);
      chk("halt_count", 32'(cycle_count), 6);
      chk("halt_done", 32'(done), 1);
      set_elems(0);
      tick(); tick();
      chk("held_pass", 32'(pass), 1);
      set_elems(0);
      elements[3*XLEN +: XLEN] = 16'd5;
      expected[3*XLEN +: XLEN] = 16'd7;
      run(1);
      chk("loop_pass", 32'(pass), 0);
      chk("loop_mask", 32'(fail_mask), 32'h08);
      chk("loop_timeout", 32'(timeout), 0);
      chk("loop_count", 32'(cycle_count), 3);
      run(2);
      chk("to_timeout", 32'(timeout), 1);
      chk("to_pass", 32'(pass), 0);
      chk("to_count", 32'(cycle_count), 16);
      chk("to_mask", 32'(fail_mask), 0);
      set_elems(0);
      run(4);
      chk("edge_timeout", 32'(timeout), 0);
      chk("edge_count", 32'(cycle_count), 16);
      chk("edge_pass", 32'(pass), 1);
      start = 1;
      tick();
      start = 0;
      for (int i = 0; i < RST + 2; i++) begin pc_out = XLEN'(16'h300 + 4 * i); tick(); end
      reset = 0; start = 1;
      tick();
      chk("abort_core_reset", 32'(core_reset), 1);
      chk("abort_running", 32'(running), 0);
      chk("abort_count", 32'(cycle_count), 0);
      chk("abort_pass", 32'(pass), 0);
      reset = 1; start = 0;
      tick();
      chk("abort_idle", 32'(done), 0);
      for (int r = 0; r < 30; r++) begin
         set_elems(1);
         run(3);
         tick();
      end
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
